// File: rtl/egm_seq_pkg.sv
// Shared types and constants for the EGM stimulus sequencer.
package egm_seq_pkg;

    localparam int LAT_W_DEF   = 16;
    localparam int NUM_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 50000;

    typedef enum logic [1:0] {IDLE, ASSERT, GAP, DONE} seq_state_t;

    // egm_leds = {busy, done_sticky, miss_seen, stimulus}
    localparam int LED_STIM = 0;
    localparam int LED_MISS = 1;
    localparam int LED_DONE = 2;
    localparam int LED_BUSY = 3;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a registered rising-edge pulse aligned to the synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            rise  <= meta & ~level;
        end
    end

endmodule

// File: rtl/egm_stim_sequencer.sv
// Issues a train of stimulus pulses to the EGM, times each response edge and
// keeps min/max/sum/miss statistics for the run.
module egm_stim_sequencer
    import egm_seq_pkg::*;
#(
    parameter int LAT_W   = LAT_W_DEF,
    parameter int NUM_W   = NUM_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clkin_50,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LAT_W-1:0]       period,
    input  logic [NUM_W-1:0]       num_events,
    input  logic                   response,
    output logic                   stimulus,
    output logic                   busy,
    output logic                   done,
    output logic                   lat_valid,
    output logic [LAT_W-1:0]       lat_value,
    output logic [LAT_W-1:0]       lat_min,
    output logic [LAT_W-1:0]       lat_max,
    output logic [LAT_W+NUM_W-1:0] lat_sum,
    output logic [NUM_W-1:0]       miss_count,
    output logic [3:0]             egm_leds
);

    localparam int SUM_W = LAT_W + NUM_W;
    localparam logic [LAT_W-1:0] LAT_ONES = '1;
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE  = NUM_W'(1);
    localparam logic [LAT_W-1:0] TO_LAST  = LAT_W'(TIMEOUT - 1);

    seq_state_t       state, state_n;
    logic [LAT_W-1:0] lat_cnt, per_cnt, period_q;
    logic [NUM_W-1:0] ev_cnt;
    logic             resp_level, resp_rise;
    logic             done_sticky, miss_seen;
    logic             go, degenerate, hit, miss, rearm, kill;

    sync_edge_det u_resp_sync (
        .clk   (clkin_50),
        .rst_n (rst_n),
        .din   (response),
        .level (resp_level),
        .rise  (resp_rise)
    );

    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        go         = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        rearm      = 1'b0;
        degenerate = (num_events == '0) || (period == '0);
        kill       = abort && (state != IDLE);
        case (state)
            IDLE: if (start) begin
                go      = 1'b1;
                state_n = degenerate ? DONE : ASSERT;
            end
            // A response edge in the timeout cycle still counts as answered.
            ASSERT: if (resp_rise) begin
                hit     = 1'b1;
                state_n = GAP;
            end else if (lat_cnt == TO_LAST) begin
                miss    = 1'b1;
                state_n = GAP;
            end
            GAP: if (ev_cnt == '0) begin
                state_n = DONE;
            end else if ((per_cnt >= period_q - LAT_ONE) && !resp_level) begin
                rearm   = 1'b1;
                state_n = ASSERT;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
            hit     = 1'b0;
            miss    = 1'b0;
            rearm   = 1'b0;
        end
    end

    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            stimulus    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lat_valid   <= 1'b0;
            lat_value   <= '0;
            lat_min     <= LAT_ONES;
            lat_max     <= '0;
            lat_sum     <= '0;
            miss_count  <= '0;
            done_sticky <= 1'b0;
            miss_seen   <= 1'b0;
            lat_cnt     <= '0;
            per_cnt     <= '0;
            period_q    <= '0;
            ev_cnt      <= '0;
        end else begin
            lat_valid <= 1'b0;
            done      <= (state_n == DONE);
            if (go) begin
                period_q    <= period;
                ev_cnt      <= num_events;
                lat_min     <= LAT_ONES;
                lat_max     <= '0;
                lat_sum     <= '0;
                miss_count  <= '0;
                done_sticky <= 1'b0;
                miss_seen   <= 1'b0;
                lat_cnt     <= '0;
                per_cnt     <= '0;
                busy        <= !degenerate;
                stimulus    <= !degenerate;
            end
            if (state == ASSERT && lat_cnt != LAT_ONES) lat_cnt <= lat_cnt + LAT_ONE;
            if ((state == ASSERT || state == GAP) && per_cnt != LAT_ONES)
                per_cnt <= per_cnt + LAT_ONE;
            if (hit) begin
                lat_value <= lat_cnt;
                lat_valid <= 1'b1;
                if (lat_cnt < lat_min) lat_min <= lat_cnt;
                if (lat_cnt > lat_max) lat_max <= lat_cnt;
                lat_sum <= lat_sum + {{NUM_W{1'b0}}, lat_cnt};
            end
            if (miss) begin
                miss_count <= miss_count + NUM_ONE;
                miss_seen  <= 1'b1;
            end
            if (hit || miss) begin
                stimulus <= 1'b0;
                ev_cnt   <= ev_cnt - NUM_ONE;
            end
            if (rearm) begin
                stimulus <= 1'b1;
                lat_cnt  <= '0;
                per_cnt  <= '0;
            end
            if (state_n == DONE) done_sticky <= 1'b1;
            if (state_n == DONE || kill) busy <= 1'b0;
            if (kill) stimulus <= 1'b0;
        end
    end

    assign egm_leds[LED_BUSY] = busy;
    assign egm_leds[LED_DONE] = done_sticky;
    assign egm_leds[LED_MISS] = miss_seen;
    assign egm_leds[LED_STIM] = stimulus;

    logic [SUM_W-1:0] unused_sum_w;
    assign unused_sum_w = '0;

endmodule

// File: tb/tb_egm_stim_sequencer.sv
// Bench for egm_stim_sequencer: directed and random runs checked against a
// timestamp-level model of pulse widths, spacings and latency statistics.
module tb_egm_stim_sequencer;

    localparam int LAT_W = 16;
    localparam int NUM_W = 8;
    localparam int TO    = 50;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, response = 1'b0;
    logic [LAT_W-1:0]       period = '0;
    logic [NUM_W-1:0]       num_events = '0;
    logic                   stimulus, busy, done, lat_valid;
    logic [LAT_W-1:0]       lat_value, lat_min, lat_max;
    logic [LAT_W+NUM_W-1:0] lat_sum;
    logic [NUM_W-1:0]       miss_count;
    logic [3:0]             egm_leds;

    egm_stim_sequencer #(.LAT_W(LAT_W), .NUM_W(NUM_W), .TIMEOUT(TO)) dut (
        .clkin_50(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .period(period), .num_events(num_events), .response(response),
        .stimulus(stimulus), .busy(busy), .done(done), .lat_valid(lat_valid),
        .lat_value(lat_value), .lat_min(lat_min), .lat_max(lat_max),
        .lat_sum(lat_sum), .miss_count(miss_count), .egm_leds(egm_leds)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge; tasks only read it.
    int   rises[$], falls[$], dones[$], lats[$];
    int   busy_cnt = 0;
    logic stim_prev = 1'b0;
    always @(negedge clk) begin
        if (stimulus && !stim_prev) rises.push_back(cyc);
        if (!stimulus && stim_prev) falls.push_back(cyc);
        if (lat_valid) lats.push_back(int'(lat_value));
        if (done) dones.push_back(cyc);
        if (busy) busy_cnt <= busy_cnt + 1;
        stim_prev <= stimulus;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_stim(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (stimulus == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stim"}, stimulus, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_lvalid"}, lat_valid, 0);
        chk({tag, "_lval"}, lat_value, 0);
        chk({tag, "_lmin"}, lat_min, 16'hFFFF);
        chk({tag, "_lmax"}, lat_max, 0);
        chk({tag, "_lsum"}, lat_sum, 0);
        chk({tag, "_miss"}, miss_count, 0);
        chk({tag, "_leds"}, egm_leds, 0);
    endtask

    // Per-event response behaviour: hit with delay d and hold h, or no answer.
    bit ev_hit[8];
    int ev_d[8];
    int ev_h[8];

    task automatic pulse_start(input int p, input int n, output int s);
        @(posedge clk);
        #1;
        period = LAT_W'(p); num_events = NUM_W'(n); start = 1'b1; s = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_case(input string tag, input int p, input int n, input bit poke);
        int r0, f0, l0, d0, b0, s, hits, misses, sum, mn, mx, lcur;
        int w[8];
        int sp[8];
        int lexp[$];
        bit ok;
        r0 = rises.size(); f0 = falls.size(); l0 = lats.size(); d0 = dones.size();
        @(negedge clk);
        b0 = busy_cnt;
        pulse_start(p, n, s);
        for (int i = 0; i < n; i++) begin
            wait_stim(1'b1, 300, ok);
            if (!ok) begin chk({tag, "_rise_wait"}, 0, 1); break; end
            if (ev_hit[i]) begin
                if (poke && i == 1) begin
                    // A start during the run must not disturb it.
                    start = 1'b1; period = 7; num_events = 1;
                    @(posedge clk);
                    #1 start = 1'b0;
                    repeat (ev_d[i] - 1) @(posedge clk);
                    #1;
                end else begin
                    repeat (ev_d[i]) @(posedge clk);
                    if (ev_d[i] > 0) #1;
                end
                response = 1'b1;
                wait_stim(1'b0, 300, ok);
                if (!ok) begin chk({tag, "_fall_wait"}, 0, 1); break; end
                repeat (ev_h[i]) @(negedge clk);
                response = 1'b0;
            end else begin
                wait_stim(1'b0, 300, ok);
                if (!ok) begin chk({tag, "_fall_wait"}, 0, 1); break; end
            end
        end
        response = 1'b0;
        for (int k = 0; k < 400 && dones.size() == d0; k++) @(negedge clk);
        repeat (2) @(negedge clk);

        // Reference: latency = delay + 2 sync cycles; a pulse stays high latency+1
        // cycles (TIMEOUT if unanswered); the next rise waits for both the period
        // and the synchronized response to read low (3 cycles after it drops).
        hits = 0; misses = 0; sum = 0; mn = 'hFFFF; mx = 0;
        for (int i = 0; i < n; i++) begin
            if (ev_hit[i]) begin
                lcur = ev_d[i] + 2;
                lexp.push_back(lcur);
                hits++; sum += lcur;
                if (lcur < mn) mn = lcur;
                if (lcur > mx) mx = lcur;
                w[i]  = lcur + 1;
                sp[i] = (p > lcur + 4 + ev_h[i]) ? p : lcur + 4 + ev_h[i];
            end else begin
                misses++;
                w[i]  = TO;
                sp[i] = (p > TO + 1) ? p : TO + 1;
            end
        end

        chk({tag, "_rises"}, rises.size() - r0, n);
        chk({tag, "_dones"}, dones.size() - d0, 1);
        if (rises.size() - r0 == n && falls.size() - f0 == n) begin
            chk({tag, "_first"}, rises[r0], s + 1);
            for (int i = 0; i < n; i++)
                chk($sformatf("%s_w%0d", tag, i), falls[f0+i] - rises[r0+i], w[i]);
            for (int i = 0; i + 1 < n; i++)
                chk($sformatf("%s_sp%0d", tag, i), rises[r0+i+1] - rises[r0+i], sp[i]);
            if (dones.size() > d0) begin
                chk({tag, "_done_at"}, dones[d0], rises[r0+n-1] + w[n-1] + 1);
                chk({tag, "_busy_len"}, busy_cnt - b0, dones[d0] - rises[r0]);
            end
        end
        chk({tag, "_nlat"}, lats.size() - l0, hits);
        for (int i = 0; i < hits && l0 + i < lats.size(); i++)
            chk($sformatf("%s_lat%0d", tag, i), lats[l0+i], lexp[i]);
        if (hits > 0) chk({tag, "_lval"}, lat_value, lexp[hits-1]);
        chk({tag, "_lmin"}, lat_min, mn);
        chk({tag, "_lmax"}, lat_max, mx);
        chk({tag, "_lsum"}, lat_sum, sum);
        chk({tag, "_miss"}, miss_count, misses);
        chk({tag, "_leds"}, egm_leds, 4 + ((misses > 0) ? 2 : 0));
    endtask

    task automatic run_degen(input string tag, input int p, input int n);
        int r0, d0, b0, s;
        r0 = rises.size(); d0 = dones.size();
        @(negedge clk);
        b0 = busy_cnt;
        pulse_start(p, n, s);
        repeat (5) @(negedge clk);
        chk({tag, "_dones"}, dones.size() - d0, 1);
        if (dones.size() > d0) chk({tag, "_done_at"}, dones[d0], s + 1);
        chk({tag, "_rises"}, rises.size() - r0, 0);
        chk({tag, "_busy"}, busy_cnt - b0, 0);
        chk({tag, "_lmin"}, lat_min, 16'hFFFF);
        chk({tag, "_leds"}, egm_leds, 4);
    endtask

    task automatic set_events(input int n, input bit hit, input int d, input int h);
        for (int i = 0; i < n; i++) begin
            ev_hit[i] = hit; ev_d[i] = d; ev_h[i] = h;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, l0, d0, n, p;
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset("rst0");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_events(3, 1'b1, 10, 0);
        run_case("basic", 100, 3, 1'b1);

        set_events(2, 1'b0, 0, 0);
        run_case("timeout", 60, 2, 1'b0);

        set_events(2, 1'b1, 28, 0);
        run_case("slow", 20, 2, 1'b0);

        set_events(3, 1'b1, 5, 40);
        run_case("stuck", 20, 3, 1'b0);

        set_events(2, 1'b1, TO - 3, 0);
        ev_hit[1] = 1'b0;
        run_case("coinc", 60, 2, 1'b0);

        run_degen("zero_n", 10, 0);
        run_degen("zero_p", 0, 3);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 5);
            p = $urandom_range(1, 90);
            for (int i = 0; i < n; i++) begin
                ev_hit[i] = ($urandom_range(0, 3) != 0);
                ev_d[i]   = $urandom_range(0, TO - 3);
                ev_h[i]   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
            end
            run_case($sformatf("rnd%0d", r), p, n, 1'b0);
        end

        // Abort during the second pulse of five.
        l0 = lats.size(); d0 = dones.size();
        pulse_start(100, 5, s);
        wait_stim(1'b1, 300, ok);
        repeat (10) @(posedge clk);
        #1 response = 1'b1;
        wait_stim(1'b0, 300, ok);
        response = 1'b0;
        wait_stim(1'b1, 300, ok);
        chk("abort_reached", ok, 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_stim", stimulus, 0);
        chk("abort_busy", busy, 0);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_dones", dones.size() - d0, 0);
        chk("abort_nlat", lats.size() - l0, 1);
        chk("abort_lsum", lat_sum, 12);
        chk("abort_leds", egm_leds, 0);

        // Asynchronous reset in the gap after the first answered pulse.
        pulse_start(100, 3, s);
        wait_stim(1'b1, 300, ok);
        repeat (10) @(posedge clk);
        #1 response = 1'b1;
        wait_stim(1'b0, 300, ok);
        response = 1'b0;
        repeat (5) @(posedge clk);
        chk("pre_rst_lval", lat_value, 12);
        #3 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_stim", stimulus, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
